// File: rtl/mem_pkg.sv
// Shared encodings for the store buffer's memory side: access size and drain FSM state.
package mem_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_WORD = 2'b10
    } size_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } drain_state_e;

    // Word wins over half, half over byte; byte is what remains when neither is set.
    function automatic size_e encode_size(input logic sw, input logic sh);
        if (sw) begin
            return SIZE_WORD;
        end
        if (sh) begin
            return SIZE_HALF;
        end
        return SIZE_BYTE;
    endfunction

endpackage

// File: rtl/store_buffer_if.sv
// RAM write port driven by the store buffer: one request at a time, held until acknowledged.
interface store_buffer_if
    import mem_pkg::*;
#(
    parameter int WIDTH = 32
) ();

    // Handshake: mem_req high presents mem_addr/mem_wdata/mem_size; they stay stable
    // until a cycle with mem_ack high, at whose closing edge the request is consumed.
    // With mem_req low all payload fields read as zero and mem_ack is ignored.
    logic             mem_req;
    size_e            mem_size;
    logic [WIDTH-1:0] mem_addr;
    logic [WIDTH-1:0] mem_wdata;
    logic             mem_ack;

    modport master (
        output mem_req,
        output mem_size,
        output mem_addr,
        output mem_wdata,
        input  mem_ack
    );

    modport slave (
        input  mem_req,
        input  mem_size,
        input  mem_addr,
        input  mem_wdata,
        output mem_ack
    );

endinterface

// File: rtl/sbuf_fifo.sv
// Circular storage for pending stores: entry arrays, head/tail pointers and occupancy count.
module sbuf_fifo
    import mem_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            push,
    input  logic [WIDTH-1:0]                push_addr,
    input  logic [WIDTH-1:0]                push_data,
    input  size_e                           push_size,
    input  logic                            pop,
    output logic [WIDTH-1:0]                head_addr,
    output logic [WIDTH-1:0]                head_data,
    output size_e                           head_size,
    output logic [$clog2(DEPTH):0]          count,
    output logic [DEPTH-1:0][WIDTH-3:0]     entry_word,
    output logic [DEPTH-1:0]                entry_valid
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DEPTH-1:0][WIDTH-1:0] addr_mem;
    logic [WIDTH-1:0]            data_mem [DEPTH];
    size_e                       size_mem [DEPTH];
    logic [PW-1:0]               head;
    logic [PW-1:0]               tail;
    logic [CW-1:0]               cnt;

    // DEPTH is a power of two, so pointer wrap is plain overflow.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else begin
            if (push) begin
                tail <= tail + PW'(1);
            end
            if (pop) begin
                head <= head + PW'(1);
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[tail] <= push_addr;
            data_mem[tail] <= push_data;
            size_mem[tail] <= push_size;
        end
    end

    // A slot is live when its distance from head is below the occupancy.
    always_comb begin
        entry_valid = '0;
        entry_word  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            entry_valid[i] = {1'b0, PW'(i) - head} < cnt;
            entry_word[i]  = addr_mem[i][WIDTH-1:2];
        end
    end

    assign head_addr = addr_mem[head];
    assign head_data = data_mem[head];
    assign head_size = size_mem[head];
    assign count     = cnt;

endmodule

// File: rtl/store_buffer.sv
// Store buffer between the memory stage and RAM: queues stores, drains them one at a time,
// and stalls the pipeline on a full buffer or a load that hits a pending store's word.
module store_buffer
    import mem_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   sw,
    input  logic                   sh,
    input  logic                   sb,
    input  logic [WIDTH-1:0]       ALUResult_M,
    input  logic [WIDTH-1:0]       writeData_M,
    input  logic                   loadIns,
    output logic                   stall_M,
    store_buffer_if.master         mem,
    output logic                   empty,
    output drain_state_e           dbg_state,
    output logic [$clog2(DEPTH):0] dbg_count
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    drain_state_e               state;
    drain_state_e               state_next;
    logic                       store;
    logic                       full;
    logic                       push;
    logic                       pop;
    logic                       load_hazard;
    logic [DEPTH-1:0]           word_match;
    logic [WIDTH-1:0]           head_addr;
    logic [WIDTH-1:0]           head_data;
    size_e                      head_size;
    logic [CW-1:0]              count;
    logic [DEPTH-1:0][WIDTH-3:0] entry_word;
    logic [DEPTH-1:0]           entry_valid;

    assign store = sw | sh | sb;
    assign full  = (count == FULL_COUNT);
    // A full buffer refuses the store even when an ack frees a slot this same cycle.
    assign push  = store && !full;
    assign pop   = (state == ST_REQ) && mem.mem_ack;

    sbuf_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push        (push),
        .push_addr   (ALUResult_M),
        .push_data   (writeData_M),
        .push_size   (encode_size(sw, sh)),
        .pop         (pop),
        .head_addr   (head_addr),
        .head_data   (head_data),
        .head_size   (head_size),
        .count       (count),
        .entry_word  (entry_word),
        .entry_valid (entry_valid)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // REQ is held exactly while the buffer will be non-empty after this edge.
    always_comb begin
        state_next    = state;
        mem.mem_req   = 1'b0;
        mem.mem_addr  = '0;
        mem.mem_wdata = '0;
        mem.mem_size  = SIZE_BYTE;
        case (state)
            ST_IDLE: begin
                if (push) begin
                    state_next = ST_REQ;
                end
            end
            ST_REQ: begin
                mem.mem_req   = 1'b1;
                mem.mem_addr  = head_addr;
                mem.mem_wdata = head_data;
                mem.mem_size  = head_size;
                if (pop && !push && count == CW'(1)) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Loads compare at word granularity, so any byte of a pending word blocks the load.
    always_comb begin
        word_match = '0;
        for (int i = 0; i < DEPTH; i++) begin
            word_match[i] = entry_valid[i] && (entry_word[i] == ALUResult_M[WIDTH-1:2]);
        end
    end

    assign load_hazard = loadIns && (|word_match);
    assign stall_M     = (store && full) || load_hazard;
    assign empty       = (count == '0);
    assign dbg_state   = state;
    assign dbg_count   = count;

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: a queue model of pending stores checked every cycle,
// plus hand-computed expectations at the interesting points of each scenario.
module tb_store_buffer;
    import mem_pkg::*;

    localparam int WIDTH = 32;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             sw = 1'b0;
    logic             sh = 1'b0;
    logic             sb = 1'b0;
    logic             load_ins = 1'b0;
    logic [WIDTH-1:0] alu_result = '0;
    logic [WIDTH-1:0] write_data = '0;
    logic             stall;
    logic             empty;
    drain_state_e     dbg_state;
    logic [CW-1:0]    dbg_count;

    store_buffer_if #(.WIDTH(WIDTH)) mem ();

    store_buffer #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sw          (sw),
        .sh          (sh),
        .sb          (sb),
        .ALUResult_M (alu_result),
        .writeData_M (write_data),
        .loadIns     (load_ins),
        .stall_M     (stall),
        .mem         (mem.master),
        .empty       (empty),
        .dbg_state   (dbg_state),
        .dbg_count   (dbg_count)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard / model ----------------
    logic [WIDTH-1:0] exp_addr_q[$];
    logic [WIDTH-1:0] exp_data_q[$];
    logic [1:0]       exp_size_q[$];
    int n_tests = 0;
    int n_fail  = 0;
    bit check_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit model_hazard(input logic [WIDTH-1:0] addr);
        foreach (exp_addr_q[i]) begin
            if (exp_addr_q[i][WIDTH-1:2] == addr[WIDTH-1:2]) begin
                return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    // Pending stores as a plain queue: a request is outstanding whenever one is queued.
    always @(posedge clk) begin
        if (!rst_n) begin
            exp_addr_q.delete();
            exp_data_q.delete();
            exp_size_q.delete();
        end else begin
            bit do_pop;
            bit do_push;
            do_pop  = (exp_addr_q.size() > 0) && mem.mem_ack;
            do_push = (sw || sh || sb) && (exp_addr_q.size() < DEPTH);
            if (do_pop) begin
                void'(exp_addr_q.pop_front());
                void'(exp_data_q.pop_front());
                void'(exp_size_q.pop_front());
            end
            if (do_push) begin
                exp_addr_q.push_back(alu_result);
                exp_data_q.push_back(write_data);
                exp_size_q.push_back(sw ? 2'b10 : (sh ? 2'b01 : 2'b00));
            end
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            int  n;
            bit  busy;
            bit  exp_stall;
            n         = exp_addr_q.size();
            busy      = (n > 0);
            exp_stall = ((sw || sh || sb) && n == DEPTH) || (load_ins && model_hazard(alu_result));
            check("cyc mem_req", mem.mem_req, busy);
            check("cyc mem_addr", mem.mem_addr, busy ? exp_addr_q[0] : '0);
            check("cyc mem_wdata", mem.mem_wdata, busy ? exp_data_q[0] : '0);
            check("cyc mem_size", mem.mem_size, busy ? exp_size_q[0] : 2'b00);
            check("cyc empty", empty, (n == 0));
            check("cyc count", dbg_count, n);
            check("cyc stall", stall, exp_stall);
            check("cyc state", dbg_state, busy ? ST_REQ : ST_IDLE);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic w, input logic h, input logic b,
                         input logic [WIDTH-1:0] addr, input logic [WIDTH-1:0] data);
        sw         = w;
        sh         = h;
        sb         = b;
        alu_result = addr;
        write_data = data;
    endtask

    task automatic clear_in();
        sw = 1'b0;
        sh = 1'b0;
        sb = 1'b0;
    endtask

    task automatic drain(input int n);
        mem.mem_ack = 1'b1;
        repeat (n) tick();
        mem.mem_ack = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected end by 100000");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed stimulus ----------------
    initial begin
        mem.mem_ack = 1'b0;

        // Reset
        tick();
        tick();
        check_en = 1'b1;
        @(negedge clk);
        check("rst mem_req", mem.mem_req, 1'b0);
        check("rst empty", empty, 1'b1);
        check("rst stall", stall, 1'b0);
        tick();
        rst_n = 1'b1;

        // Single word store, acked on the second request cycle
        store(1, 0, 0, 32'h10, 32'hDEAD_BEEF);
        @(negedge clk);
        check("A pre empty", empty, 1'b1);
        check("A pre mem_req", mem.mem_req, 1'b0);
        tick();
        clear_in();
        @(negedge clk);
        check("A mem_req", mem.mem_req, 1'b1);
        check("A mem_size", mem.mem_size, 2'b10);
        check("A mem_addr", mem.mem_addr, 32'h10);
        check("A mem_wdata", mem.mem_wdata, 32'hDEAD_BEEF);
        tick();
        mem.mem_ack = 1'b1;
        @(negedge clk);
        check("A held addr", mem.mem_addr, 32'h10);
        check("A held data", mem.mem_wdata, 32'hDEAD_BEEF);
        tick();
        mem.mem_ack = 1'b0;
        @(negedge clk);
        check("A empty after", empty, 1'b1);
        check("A mem_req after", mem.mem_req, 1'b0);
        check("A addr zero", mem.mem_addr, 32'h0);

        // Five back-to-back byte stores into a four-deep buffer
        tick();
        for (int i = 0; i < 4; i++) begin
            store(0, 0, 1, 32'h40 + 32'(4 * i), 32'hA0 + 32'(i));
            tick();
        end
        store(0, 0, 1, 32'h50, 32'hA4);
        @(negedge clk);
        check("B stall full", stall, 1'b1);
        check("B count full", dbg_count, 4);
        tick();
        @(negedge clk);
        check("B stall held", stall, 1'b1);
        tick();
        mem.mem_ack = 1'b1;
        @(negedge clk);
        check("B stall on ack", stall, 1'b1);
        check("B head first", mem.mem_addr, 32'h40);
        tick();
        mem.mem_ack = 1'b0;
        @(negedge clk);
        check("B stall released", stall, 1'b0);
        check("B count 3", dbg_count, 3);
        check("B head second", mem.mem_addr, 32'h44);
        tick();
        clear_in();
        @(negedge clk);
        check("B count back 4", dbg_count, 4);
        tick();
        drain(4);
        check("B drained", empty, 1'b1);

        // Load hazard against a pending half store
        store(0, 1, 0, 32'h22, 32'h1234);
        tick();
        clear_in();
        load_ins   = 1'b1;
        alu_result = 32'h20;
        @(negedge clk);
        check("C hazard", stall, 1'b1);
        tick();
        @(negedge clk);
        check("C hazard held", stall, 1'b1);
        tick();
        alu_result = 32'h24;
        @(negedge clk);
        check("C other word", stall, 1'b0);
        tick();
        alu_result  = 32'h20;
        mem.mem_ack = 1'b1;
        @(negedge clk);
        check("C hazard on ack", stall, 1'b1);
        tick();
        mem.mem_ack = 1'b0;
        @(negedge clk);
        check("C hazard cleared", stall, 1'b0);
        check("C empty", empty, 1'b1);
        tick();
        load_ins   = 1'b0;
        alu_result = '0;

        // Simultaneous push and pop at count 3, wrapping the pointers
        for (int i = 0; i < 3; i++) begin
            store(1, 0, 0, 32'h200 + 32'(4 * i), 32'h1000 + 32'(i));
            tick();
        end
        check("D count 3", dbg_count, 3);
        for (int k = 0; k < 6; k++) begin
            store(1, 0, 0, 32'h300 + 32'(4 * k), 32'h2000 + 32'(k));
            mem.mem_ack = 1'b1;
            tick();
            check("D count steady", dbg_count, 3);
        end
        clear_in();
        check("D head after wrap", mem.mem_addr, 32'h30C);
        check("D data after wrap", mem.mem_wdata, 32'h2003);
        repeat (3) tick();
        mem.mem_ack = 1'b0;
        check("D drained", empty, 1'b1);

        // Reset in the middle of a drain
        store(1, 0, 0, 32'h500, 32'h5);
        tick();
        store(1, 0, 0, 32'h504, 32'h6);
        tick();
        clear_in();
        @(negedge clk);
        check("E mem_req before", mem.mem_req, 1'b1);
        check("E count 2", dbg_count, 2);
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        check("E mem_req after rst", mem.mem_req, 1'b0);
        check("E empty after rst", empty, 1'b1);
        tick();
        mem.mem_ack = 1'b1;
        tick();
        tick();
        mem.mem_ack = 1'b0;
        @(negedge clk);
        check("E late ack req", mem.mem_req, 1'b0);
        check("E late ack empty", empty, 1'b1);
        check("E late ack count", dbg_count, 0);

        // Size priority with several request lines high
        tick();
        store(1, 0, 1, 32'h600, 32'hCAFE_F00D);
        tick();
        store(0, 1, 1, 32'h604, 32'hBEEF);
        tick();
        clear_in();
        @(negedge clk);
        check("F word over byte", mem.mem_size, 2'b10);
        check("F count 2", dbg_count, 2);
        tick();
        drain(1);
        @(negedge clk);
        check("F half over byte", mem.mem_size, 2'b01);
        check("F second addr", mem.mem_addr, 32'h604);
        tick();
        drain(1);
        @(negedge clk);
        check("F empty", empty, 1'b1);

        tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning data/address width.
REQ-002 SHALL have parameter DEPTH, default 4, meaning number of buffered stores (power of two, >=2).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  synchronous, active-low reset.
REQ-005 SHALL have ports sw, sh, sb  input  1 each  store-word/half/byte request from memory stage.
REQ-006 SHALL have port ALUResult_M  input  WIDTH  store or load byte address.
REQ-007 SHALL have port writeData_M  input  WIDTH  store data, unaligned (low bits significant for sh/sb).
REQ-008 SHALL have port loadIns  input  1  a load is in the memory stage this cycle.
REQ-009 SHALL have port stall_M  output  1  freeze memory stage and everything upstream.
REQ-010 SHALL have ports mem_req  output  1, mem_size  output  2, mem_addr  output  WIDTH, mem_wdata  output  WIDTH  RAM write request.
REQ-011 SHALL have port mem_ack  input  1  RAM accepted the current request.
REQ-012 SHALL have port empty  output  1  no pending stores.

Function
REQ-013 SHALL encode size as 00 byte, 01 half, 10 word; with more than one of sw/sh/sb high, priority SHALL be sw > sh > sb.
REQ-014 SHALL hold a circular FIFO of DEPTH entries {addr, data, size} with head/tail pointers wrapping modulo DEPTH and a count 0..DEPTH.
REQ-015 SHALL enqueue a store at the clock edge when any of sw/sh/sb is high and count < DEPTH, regardless of mem_ack.
REQ-016 SHALL NOT enqueue when count == DEPTH, even if mem_ack pops an entry the same cycle; stall_M holds and the store is accepted next cycle.
REQ-017 SHALL drive stall_M combinationally = (store && count==DEPTH) || load_hazard.
REQ-018 SHALL compute load_hazard = loadIns && some valid entry has addr[WIDTH-1:2] == ALUResult_M[WIDTH-1:2].
REQ-019 SHALL implement drain FSM with states IDLE and REQ.
REQ-020 SHALL move IDLE->REQ at the edge where count > 0 (including the edge that enqueues into an empty buffer).
REQ-021 SHALL in REQ assert mem_req and present head entry on mem_addr/mem_wdata/mem_size, stable until mem_ack.
REQ-022 SHALL on mem_ack in REQ pop head; stay in REQ if post-update count > 0, else return to IDLE.
REQ-023 SHALL on simultaneous enqueue and pop leave count unchanged and advance both pointers.
REQ-024 SHALL hold mem_req low in IDLE; mem_addr/mem_wdata/mem_size SHALL be 0 whenever mem_req is low.
REQ-025 SHALL ignore mem_ack while in IDLE.
REQ-026 SHALL drive empty = (count == 0).
REQ-027 SHALL give a minimum latency of one cycle from store enqueue to mem_req rising.

Reset
REQ-028 SHALL on rst_n low at an edge set count=0, head=tail=0, state=IDLE; takes priority over enqueue and pop.
REQ-029 SHALL during and after reset drive mem_req=0, stall_M=0 (absent a store), and empty=1.
REQ-030 SHALL discard pending entries and any in-flight request on reset mid-drain; no further mem_req until a new store.

Structure
REQ-031 SHALL place size encoding enum and FSM state enum in shared package mem_pkg.
REQ-032 SHALL instantiate one sub-module, sbuf_fifo (storage array, pointers, count); FSM and hazard compare SHALL stay in store_buffer.

Verification
REQ-033 SHALL cover: reset, then sw addr 0x10 data 0xDEADBEEF, mem_ack after 2 cycles -> mem_req next cycle with size 10, addr 0x10, data 0xDEADBEEF held until ack; empty=1 after.
REQ-034 SHALL cover: 5 back-to-back sb with mem_ack=0, DEPTH=4 -> 4 accepted, stall_M=1 on 5th; single mem_ack -> 5th accepted next cycle, count stays 4.
REQ-035 SHALL cover: sh addr 0x22 pending, loadIns addr 0x20 -> stall_M=1 until that entry is drained; load addr 0x24 -> stall_M=0.
REQ-036 SHALL cover: count=3, store and mem_ack same cycle -> count 3, FIFO order preserved, 6 pushes/pops across wrap.
REQ-037 SHALL cover: rst_n low while mem_req=1 with 2 pending -> next cycle mem_req=0, empty=1, and a later mem_ack has no effect.
REQ-038 SHALL cover: sw and sb both high -> size 10 enqueued.
